// File: rtl/instr_dispatcher.sv
// rtl/instr_dispatcher.sv - sequences a stored 14-bit program onto a simple processor's Run/Done command handshake
module instr_dispatcher #(
    parameter int n       = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         prog_we,
    input  logic [3:0]   prog_addr,
    input  logic [13:0]  prog_data,
    input  logic [4:0]   prog_len,
    input  logic         start,
    input  logic         Done,
    input  logic [n-1:0] BusWires,
    output logic         Run,
    output logic [1:0]   Fun,
    output logic [1:0]   Rx,
    output logic [1:0]   Ry,
    output logic [n-1:0] Data,
    output logic         busy,
    output logic         finished,
    output logic         error,
    output logic [3:0]   pc,
    output logic [n-1:0] result
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FIN   = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [13:0]    r_mem [DEPTH];
    logic [3:0]     r_pc;
    logic [3:0]     w_pc_next;
    logic [4:0]     r_len;
    logic [4:0]     w_len_next;
    logic [WCW-1:0] r_wcnt;
    logic [WCW-1:0] w_wcnt_next;
    logic [WCW-1:0] w_wcnt_inc;
    logic [n-1:0]   r_result;
    logic [n-1:0]   w_result_next;
    logic           w_quiet;
    logic [13:0]    w_ins;

    logic           r_run;
    logic [1:0]     r_fun;
    logic [1:0]     r_rx;
    logic [1:0]     r_ry;
    logic [n-1:0]   r_data;
    logic           r_busy;
    logic           r_finished;
    logic           r_error;

    // Program writes are only accepted while no program is executing.
    assign w_quiet    = (r_state == IDLE) || (r_state == FIN) || (r_state == ERR);
    assign w_wcnt_inc = r_wcnt + WCW'(1);
    // The instruction presented on the command bus is the one the next pc points at.
    assign w_ins      = r_mem[w_pc_next];

    // Program memory: written when idle, deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (!reset && prog_we && w_quiet) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Next-state logic: start handling, issue/wait handshake, timeout.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_len_next    = r_len;
        w_wcnt_next   = r_wcnt;
        w_result_next = r_result;
        case (r_state)
            IDLE, FIN, ERR: begin
                if (start) begin
                    w_pc_next    = 4'd0;
                    w_len_next   = prog_len;
                    w_wcnt_next  = '0;
                    w_state_next = (prog_len == 5'd0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                // A Done still high from the previous command is stale here.
                w_wcnt_next  = '0;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (Done) begin
                    w_result_next = BusWires;
                    if ({1'b0, r_pc} == (r_len - 5'd1)) begin
                        w_state_next = FIN;
                    end else begin
                        w_pc_next    = r_pc + 4'd1;
                        w_state_next = ISSUE;
                    end
                end else begin
                    w_wcnt_next = w_wcnt_inc;
                    if (w_wcnt_inc == WCW'(TIMEOUT)) begin
                        w_state_next = ERR;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= 4'd0;
            r_len      <= 5'd0;
            r_wcnt     <= '0;
            r_result   <= '0;
            r_run      <= 1'b0;
            r_fun      <= 2'd0;
            r_rx       <= 2'd0;
            r_ry       <= 2'd0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_len      <= w_len_next;
            r_wcnt     <= w_wcnt_next;
            r_result   <= w_result_next;
            r_run      <= (w_state_next == ISSUE);
            r_busy     <= (w_state_next == ISSUE) || (w_state_next == WAIT);
            r_finished <= (w_state_next == FIN);
            r_error    <= (w_state_next == ERR);
            if (w_state_next == ISSUE) begin
                r_fun  <= w_ins[13:12];
                r_rx   <= w_ins[11:10];
                r_ry   <= w_ins[9:8];
                r_data <= n'(w_ins[7:0]);
            end else if (w_state_next != WAIT) begin
                r_fun  <= 2'd0;
                r_rx   <= 2'd0;
                r_ry   <= 2'd0;
                r_data <= '0;
            end
        end
    end

    assign Run      = r_run;
    assign Fun      = r_fun;
    assign Rx       = r_rx;
    assign Ry       = r_ry;
    assign Data     = r_data;
    assign busy     = r_busy;
    assign finished = r_finished;
    assign error    = r_error;
    assign pc       = r_pc;
    assign result   = r_result;

endmodule

// File: tb/tb_instr_dispatcher.sv
// tb/tb_instr_dispatcher.sv - scoreboard bench for instr_dispatcher with a behavioural processor model
module tb_instr_dispatcher;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [13:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        Done;
    logic [7:0]  BusWires;
    logic        Run;
    logic [1:0]  Fun, Rx, Ry;
    logic [7:0]  Data;
    logic        busy, finished, error;
    logic [3:0]  pc;
    logic [7:0]  result;

    instr_dispatcher #(.n(8), .DEPTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .Done(Done),
        .BusWires(BusWires), .Run(Run), .Fun(Fun), .Rx(Rx), .Ry(Ry), .Data(Data),
        .busy(busy), .finished(finished), .error(error), .pc(pc), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 command, 1 finished, 2 error
        logic [1:0] fun, rx, ry;
        logic [7:0] data;
        logic [3:0] pc;
        logic [7:0] res;
        bit         chk_res;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // processor model controls
    int  no_done_pc  = -1;
    int  fixed_delay = 0;
    bit  hold_mode   = 1'b0;

    logic [13:0] prog1 [6] = '{14'h0033, 14'h0422, 14'h0811, 14'h2100, 14'h1C00, 14'h3600};
    logic [7:0]  res1  [6] = '{8'h33, 8'h22, 8'h11, 8'h55, 8'h55, 8'h11};

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [13:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        prog_len = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_cmd(input logic [13:0] p, input int idx, input logic [7:0] r);
        ev_t e;
        e.kind = 0; e.fun = p[13:12]; e.rx = p[11:10]; e.ry = p[9:8]; e.data = p[7:0];
        e.pc = 4'(idx); e.res = r; e.chk_res = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int kind, input logic [3:0] p, input logic [7:0] r);
        ev_t e;
        e.kind = kind; e.fun = 2'd0; e.rx = 2'd0; e.ry = 2'd0; e.data = 8'd0;
        e.pc = p; e.res = r; e.chk_res = (kind == 1);
        exp_q.push_back(e);
    endtask

    task automatic push_prog1(input logic [7:0] first_res, input int count, input bit with_fin);
        for (int i = 0; i < count; i++) begin
            push_cmd(prog1[i], i, (i == 0) ? first_res : res1[i-1]);
        end
        if (with_fin) push_end(1, 4'd5, 8'h11);
    endtask

    task automatic wait_done(input string nm, input int max);
        int k;
        k = 0;
        @(negedge clk);
        while (!(finished || error) && k < max) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_completes"}, {31'd0, finished | error}, 32'd1);
    endtask

    task automatic wait_run(input logic [3:0] p, input int max);
        int k;
        k = 0;
        @(negedge clk);
        while (!(Run && pc == p) && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("wait_run_seen", {31'd0, Run && pc == p}, 32'd1);
    endtask

    // Scoreboard monitor: pops an expected event whenever the DUT issues, finishes or errors.
    int cyc = 0;
    int run_cyc = 0;
    initial begin
        logic prev_run, prev_fin, prev_err;
        ev_t  e;
        prev_run = 1'b0; prev_fin = 1'b0; prev_err = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (prev_run) chk("run_one_cycle", {31'd0, Run}, 32'd0);
                if (Run || (finished && !prev_fin) || (error && !prev_err)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        if (Run) begin
                            chk("event_kind_cmd", 32'd0, e.kind);
                            chk("cmd_fun", {30'd0, Fun}, {30'd0, e.fun});
                            chk("cmd_rx", {30'd0, Rx}, {30'd0, e.rx});
                            chk("cmd_ry", {30'd0, Ry}, {30'd0, e.ry});
                            chk("cmd_data", {24'd0, Data}, {24'd0, e.data});
                            chk("cmd_pc", {28'd0, pc}, {28'd0, e.pc});
                            chk("cmd_busy", {31'd0, busy}, 32'd1);
                            if (e.chk_res) chk("cmd_prev_result", {24'd0, result}, {24'd0, e.res});
                            run_cyc = cyc;
                        end else if (finished && !prev_fin) begin
                            chk("event_kind_fin", 32'd1, e.kind);
                            chk("fin_pc", {28'd0, pc}, {28'd0, e.pc});
                            chk("fin_result", {24'd0, result}, {24'd0, e.res});
                            chk("fin_busy", {31'd0, busy}, 32'd0);
                        end else begin
                            chk("event_kind_err", 32'd2, e.kind);
                            chk("err_pc", {28'd0, pc}, {28'd0, e.pc});
                            chk("err_run", {31'd0, Run}, 32'd0);
                            chk("err_latency", cyc - run_cyc, TO + 1);
                        end
                    end
                end
            end
            prev_run = Run; prev_fin = finished; prev_err = error;
        end
    end

    // Processor model: executes each command and raises Done with the new Rx value.
    initial begin
        logic [7:0] regs [4];
        logic [1:0] m_fun, m_rx, m_ry;
        logic [7:0] m_data, val;
        logic [3:0] m_pc;
        bit         pending;
        int         cnt;
        for (int i = 0; i < 4; i++) regs[i] = 8'd0;
        Done = 1'b0; BusWires = 8'd0; pending = 1'b0; cnt = 0;
        m_fun = 2'd0; m_rx = 2'd0; m_ry = 2'd0; m_data = 8'd0; m_pc = 4'd0; val = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                Done = 1'b0; BusWires = 8'd0; pending = 1'b0;
            end else if (Run) begin
                m_fun = Fun; m_rx = Rx; m_ry = Ry; m_data = Data; m_pc = pc;
                pending = 1'b1;
                cnt = (fixed_delay != 0) ? fixed_delay : 1 + (int'(pc) % 3);
                Done = hold_mode;
                BusWires = hold_mode ? 8'hEE : 8'h00;
            end else if (pending) begin
                if (int'(m_pc) == no_done_pc) begin
                    Done = 1'b0;
                end else if (cnt <= 1) begin
                    case (m_fun)
                        2'd0:    val = m_data;
                        2'd1:    val = regs[m_ry];
                        2'd2:    val = regs[m_rx] + regs[m_ry];
                        default: val = regs[m_rx] - regs[m_ry];
                    endcase
                    regs[m_rx] = val;
                    Done = 1'b1; BusWires = val; pending = 1'b0;
                end else begin
                    cnt--; Done = 1'b0; BusWires = 8'd0;
                end
            end else begin
                Done = hold_mode;
                BusWires = hold_mode ? 8'hEE : 8'h00;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b1; prog_we = 1'b0; prog_addr = 4'd0;
        prog_data = 14'd0; prog_len = 5'd6;
        tick(); tick();
        @(negedge clk);
        chk("reset_outputs", {2'd0, Run, Fun, Rx, Ry, Data, busy, finished, error, pc, result}, 32'd0);
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);

        // Scenario 1: full program
        tick();
        for (int i = 0; i < 6; i++) prog_write(4'(i), prog1[i]);
        push_prog1(8'h00, 6, 1'b1);
        do_start(5'd6);
        wait_done("s1", 200);
        chk("s1_pc", {28'd0, pc}, 32'd5);
        chk("s1_result", {24'd0, result}, 32'h11);
        chk("s1_busy", {31'd0, busy}, 32'd0);

        // Scenario 2: entry 2 never completes
        no_done_pc = 2;
        push_prog1(8'h11, 3, 1'b0);
        push_end(2, 4'd2, 8'h22);
        tick();
        do_start(5'd6);
        wait_done("s2", 200);
        chk("s2_error", {31'd0, error}, 32'd1);
        chk("s2_pc", {28'd0, pc}, 32'd2);
        chk("s2_run", {31'd0, Run}, 32'd0);
        no_done_pc = -1;

        // Scenario 3: zero-length program, also clears error
        push_end(1, 4'd0, 8'h22);
        tick();
        do_start(5'd0);
        @(negedge clk);
        chk("s3_finished", {31'd0, finished}, 32'd1);
        chk("s3_error_cleared", {31'd0, error}, 32'd0);
        chk("s3_no_run", {31'd0, Run}, 32'd0);

        // Scenario 4: stale Done through ISSUE, start/prog_we ignored in WAIT
        hold_mode = 1'b1;
        push_prog1(8'h22, 6, 1'b1);
        tick();
        do_start(5'd6);
        wait_run(4'd1, 50);
        tick();
        start = 1'b1; prog_len = 5'd0; prog_we = 1'b1; prog_addr = 4'd3; prog_data = 14'd0;
        tick();
        start = 1'b0; prog_we = 1'b0;
        wait_done("s4", 200);
        chk("s4_result", {24'd0, result}, 32'h11);
        hold_mode = 1'b0;

        // Scenario 5: reset in WAIT of entry 3, then replay
        push_prog1(8'h11, 4, 1'b0);
        tick();
        do_start(5'd6);
        wait_run(4'd3, 50);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("s5_reset_outputs", {2'd0, Run, Fun, Rx, Ry, Data, busy, finished, error, pc, result}, 32'd0);
        chk("s5_events_consumed", exp_q.size(), 32'd0);
        exp_q.delete();
        push_prog1(8'h00, 6, 1'b1);
        tick();
        do_start(5'd6);
        wait_done("s5", 200);
        chk("s5_replay_result", {24'd0, result}, 32'h11);

        // Scenario 6: 16 loads, no pc wrap
        fixed_delay = 1;
        tick();
        for (int i = 0; i < 16; i++) begin
            prog_write(4'(i), {2'b00, 2'(i % 4), 2'b00, 8'(8'h10 + i)});
            push_cmd({2'b00, 2'(i % 4), 2'b00, 8'(8'h10 + i)}, i, (i == 0) ? 8'h11 : 8'(8'h10 + i - 1));
        end
        push_end(1, 4'd15, 8'h1F);
        do_start(5'd16);
        wait_done("s6", 400);
        tick(); tick(); tick();
        @(negedge clk);
        chk("s6_pc_no_wrap", {28'd0, pc}, 32'd15);
        chk("s6_finished_sticky", {31'd0, finished}, 32'd1);
        chk("s6_busy", {31'd0, busy}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
